// File: rtl/lsh_pkg.sv
// Shared definitions for the level sensor hub.
//   - pump_state_e : per-channel pump-fill state machine encoding
//   - ADDR_LOW_TH / ADDR_HIGH_TH : threshold register addresses
//   - LOW_TH_RST / HIGH_TH_RST   : threshold values after reset
//   - STAT_*       : bit positions inside a channel status byte
//   - pack_status  : assembles a channel status byte
package lsh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FAULT = 2'd2
    } pump_state_e;

    localparam int unsigned ADDR_LOW_TH  = 32'hE;
    localparam int unsigned ADDR_HIGH_TH = 32'hF;

    localparam logic [7:0] LOW_TH_RST  = 8'd20;
    localparam logic [7:0] HIGH_TH_RST = 8'd80;

    localparam int unsigned STAT_PUMP_BIT   = 32'd0;
    localparam int unsigned STAT_FAULT_BIT  = 32'd1;
    localparam int unsigned STAT_STICKY_BIT = 32'd2;
    localparam int unsigned STAT_TAP_LSB    = 32'd3;

    // Status byte layout: {tap_count[4:0], fault_sticky, fault, pump_req}
    function automatic logic [7:0] pack_status(
        input logic [4:0] tap_count,
        input logic       fault_sticky,
        input logic       fault,
        input logic       pump_req
    );
        logic [7:0] stat;
        stat                     = 8'd0;
        stat[STAT_PUMP_BIT]      = pump_req;
        stat[STAT_FAULT_BIT]     = fault;
        stat[STAT_STICKY_BIT]    = fault_sticky;
        stat[STAT_TAP_LSB +: 5]  = tap_count;
        return stat;
    endfunction

endpackage

// File: rtl/lsh_channel.sv
// One floating-switch channel: synchroniser, debounce, thermometer decode,
// pump-fill state machine and sticky fault flag.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   sens            : raw thermometer-coded switch vector (bit 0 lowest)
//   low_th, high_th : global hysteresis thresholds (percent)
//   sticky_clr      : status register of this channel is being read
//   level           : last valid level in percent
//   tap_count       : number of wetted switches in the last valid code
//   fault           : current code is not a thermometer code
//   fault_sticky    : a fault has been seen since the last status read
//   pump_req        : pump request, high only while filling
module lsh_channel
    import lsh_pkg::*;
#(
    parameter int unsigned TAPS       = 9,
    parameter int unsigned STEP       = 10,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [TAPS-1:0] sens,
    input  logic [7:0]      low_th,
    input  logic [7:0]      high_th,
    input  logic            sticky_clr,
    output logic [7:0]      level,
    output logic [4:0]      tap_count,
    output logic            fault,
    output logic            fault_sticky,
    output logic            pump_req
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [TAPS-1:0]  sync1_r;
    logic [TAPS-1:0]  sync2_r;
    logic [TAPS-1:0]  cand_r;
    logic [TAPS-1:0]  stable_r;
    logic [CNT_W-1:0] cnt_r;

    logic [TAPS-1:0]  stable_inc_s;
    logic             thermo_s;
    logic [7:0]       ones_s;
    logic [7:0]       level_calc_s;

    logic [7:0]       level_r;
    logic [4:0]       tap_r;
    logic             fault_r;
    logic             sticky_r;
    logic             pump_r;

    pump_state_e      state_r;
    pump_state_e      state_s;

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= sens;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a vector is accepted once the candidate has been seen
    // DEB_CYCLES times in a row. The copy keys on the counter alone so a
    // vector held exactly DEB_CYCLES cycles still gets through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_r   <= '0;
            cnt_r    <= '0;
            stable_r <= '0;
        end else begin
            if (sync2_r != cand_r) begin
                cand_r <= sync2_r;
                cnt_r  <= '0;
            end else if (cnt_r != DEB_MAX) begin
                cnt_r  <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r  <= cnt_r;
            end
            if (cnt_r == DEB_MAX) begin
                stable_r <= cand_r;
            end else begin
                stable_r <= stable_r;
            end
        end
    end

    // Thermometer check and tap count. 2^k-1 plus one has no bit in common
    // with itself; the all-ones code wraps to zero in TAPS bits.
    always_comb begin
        stable_inc_s = stable_r + TAPS'(1);
        thermo_s     = ((stable_r & stable_inc_s) == '0);
        ones_s       = 8'd0;
        for (int i = 0; i < int'(TAPS); i++) begin
            ones_s = ones_s + {7'd0, stable_r[i]};
        end
        level_calc_s = 8'(ones_s * STEP);
    end

    // Decoded level register; an invalid code keeps the last valid level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r <= 8'd0;
            tap_r   <= 5'd0;
            fault_r <= 1'b0;
        end else begin
            fault_r <= ~thermo_s;
            if (thermo_s) begin
                level_r <= level_calc_s;
                tap_r   <= ones_s[4:0];
            end else begin
                level_r <= level_r;
                tap_r   <= tap_r;
            end
        end
    end

    // Pump FSM state register and registered pump request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            pump_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pump_r  <= (state_s == ST_FILL);
        end
    end

    // Pump FSM next state; a fault overrides every other transition
    always_comb begin
        state_s = state_r;
        if (fault_r) begin
            state_s = ST_FAULT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (level_r <= low_th) begin
                        state_s = ST_FILL;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (level_r >= high_th) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_FILL;
                    end
                end
                ST_FAULT: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Sticky fault: a live fault wins over a simultaneous status read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= fault_r | (sticky_r & ~sticky_clr);
        end
    end

    assign level        = level_r;
    assign tap_count    = tap_r;
    assign fault        = fault_r;
    assign fault_sticky = sticky_r;
    assign pump_req     = pump_r;

endmodule

// File: rtl/level_sensor_hub.sv
// Multi-channel floating-switch level hub with a registered register port.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   sens_in    : raw switch vectors, channel c at [c*TAPS +: TAPS]
//   address    : register select
//   rd_en      : read strobe, data on sensOut one cycle later
//   wr_en      : write strobe (thresholds only)
//   wr_data    : write data
//   sensOut    : registered read data, held while rd_en is low
//   pump_req   : per-channel pump request
//   fault      : per-channel live invalid-code flag
// Address map: 0..N_CH-1 levels, N_CH..2*N_CH-1 status,
// 0xE low threshold, 0xF high threshold, everything else reads 0.
module level_sensor_hub
    import lsh_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned TAPS       = 9,
    parameter int unsigned STEP       = 10,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*TAPS-1:0] sens_in,
    input  logic [ADDR_W-1:0]    address,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    output logic [7:0]           sensOut,
    output logic [N_CH-1:0]      pump_req,
    output logic [N_CH-1:0]      fault
);

    logic [7:0]      low_th_r;
    logic [7:0]      high_th_r;
    logic [7:0]      sens_out_r;
    logic [7:0]      rd_data_s;

    logic [7:0]      level_s [N_CH];
    logic [4:0]      tap_s   [N_CH];
    logic [N_CH-1:0] fault_s;
    logic [N_CH-1:0] sticky_s;
    logic [N_CH-1:0] pump_s;
    logic [N_CH-1:0] sticky_clr_s;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign sticky_clr_s[c] = rd_en && (address == ADDR_W'(N_CH + c));

        lsh_channel #(
            .TAPS       (TAPS),
            .STEP       (STEP),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .sens         (sens_in[c*TAPS +: TAPS]),
            .low_th       (low_th_r),
            .high_th      (high_th_r),
            .sticky_clr   (sticky_clr_s[c]),
            .level        (level_s[c]),
            .tap_count    (tap_s[c]),
            .fault        (fault_s[c]),
            .fault_sticky (sticky_s[c]),
            .pump_req     (pump_s[c])
        );
    end

    // Threshold registers; the FSMs see the new value from the next cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            low_th_r  <= LOW_TH_RST;
            high_th_r <= HIGH_TH_RST;
        end else if (wr_en) begin
            if (address == ADDR_W'(ADDR_LOW_TH)) begin
                low_th_r <= wr_data;
            end else if (address == ADDR_W'(ADDR_HIGH_TH)) begin
                high_th_r <= wr_data;
            end else begin
                low_th_r  <= low_th_r;
                high_th_r <= high_th_r;
            end
        end else begin
            low_th_r  <= low_th_r;
            high_th_r <= high_th_r;
        end
    end

    // Read data select; unmapped addresses return zero
    always_comb begin
        rd_data_s = 8'd0;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (address == ADDR_W'(c)) begin
                rd_data_s = level_s[c];
            end else if (address == ADDR_W'(int'(N_CH) + c)) begin
                rd_data_s = pack_status(tap_s[c], sticky_s[c], fault_s[c], pump_s[c]);
            end else begin
            end
        end
        if (address == ADDR_W'(ADDR_LOW_TH)) begin
            rd_data_s = low_th_r;
        end else if (address == ADDR_W'(ADDR_HIGH_TH)) begin
            rd_data_s = high_th_r;
        end else begin
        end
    end

    // Read data register; a same-cycle write is not visible until the next read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sens_out_r <= 8'd0;
        end else if (rd_en) begin
            sens_out_r <= rd_data_s;
        end else begin
            sens_out_r <= sens_out_r;
        end
    end

    assign sensOut  = sens_out_r;
    assign pump_req = pump_s;
    assign fault    = fault_s;

endmodule
